// File: rtl/pref_pkg.sv
// Shared prefetcher types: byte addresses and cache-line numbers.
package pref_pkg;
  localparam int ADDR_SIZE = 64;
  localparam int LOG2_BLOCK_SIZE = 6;
  localparam int CLA_SIZE = ADDR_SIZE - LOG2_BLOCK_SIZE;

  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [CLA_SIZE-1:0] cla_t;
endpackage

// File: rtl/pref_recent_filter.sv
// Remembers recently issued lines; FIFO replacement via wrapping pointer.
module pref_recent_filter
  import pref_pkg::*;
#(
  parameter int FILTER_SIZE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic insert_valid_i,
  input  cla_t insert_line_i,
  input  cla_t lookup_line1_i,
  input  cla_t lookup_line2_i,
  input  cla_t lookup_line3_i,
  output logic hit1_o,
  output logic hit2_o,
  output logic hit3_o
);
  localparam int PW = $clog2(FILTER_SIZE);

  logic [FILTER_SIZE-1:0] vld_q;
  cla_t                   line_q [FILTER_SIZE];
  logic [PW-1:0]          ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      ptr_q <= '0;
    end else if (insert_valid_i) begin
      vld_q[ptr_q]  <= 1'b1;
      line_q[ptr_q] <= insert_line_i;
      ptr_q         <= ptr_q + 1'b1;
    end
  end

  always_comb begin
    hit1_o = 1'b0;
    hit2_o = 1'b0;
    hit3_o = 1'b0;
    for (int i = 0; i < FILTER_SIZE; i++) begin
      if (vld_q[i]) begin
        if (line_q[i] == lookup_line1_i) hit1_o = 1'b1;
        if (line_q[i] == lookup_line2_i) hit2_o = 1'b1;
        if (line_q[i] == lookup_line3_i) hit3_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pref_issue_queue.sv
// Dedups and block-aligns prefetch candidates, queues them in order
// and issues one per cycle over a valid/ready request port.
module pref_issue_queue
  import pref_pkg::*;
#(
  parameter int QUEUE_DEPTH = 8,
  parameter int FILTER_SIZE = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE-1:0] cand_addr1_i,
  input  logic                 cand_valid1_i,
  input  logic [ADDR_SIZE-1:0] cand_addr2_i,
  input  logic                 cand_valid2_i,
  input  logic [ADDR_SIZE-1:0] cand_addr3_i,
  input  logic                 cand_valid3_i,
  output logic [ADDR_SIZE-1:0] req_addr_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [CNT_WIDTH-1:0] issued_cnt_o,
  output logic [CNT_WIDTH-1:0] dup_drop_cnt_o,
  output logic [CNT_WIDTH-1:0] full_drop_cnt_o
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int LB = LOG2_BLOCK_SIZE;

  cla_t                 mem_q [QUEUE_DEPTH];
  logic [PW-1:0]        rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] iss_q, iss_d;
  logic [CNT_WIDTH-1:0] dup_q, dup_d;
  logic [CNT_WIDTH-1:0] full_q, full_d;

  cla_t                   line [3];
  logic [2:0]             cv, fhit;
  logic [2:0]             dup, enq, fdrop;
  logic [PW-1:0]          widx [3];
  logic [QUEUE_DEPTH-1:0] qv;
  logic                   issue;
  logic                   unused_lo;

  assign line[0] = cand_addr1_i[ADDR_SIZE-1:LB];
  assign line[1] = cand_addr2_i[ADDR_SIZE-1:LB];
  assign line[2] = cand_addr3_i[ADDR_SIZE-1:LB];
  assign cv      = {cand_valid3_i, cand_valid2_i,
                    cand_valid1_i};
  assign unused_lo = ^{cand_addr1_i[LB-1:0],
                       cand_addr2_i[LB-1:0],
                       cand_addr3_i[LB-1:0]};

  assign req_valid_o = (cnt_q != '0);
  assign issue       = req_valid_o & req_ready_i;
  assign req_addr_o  = req_valid_o
                     ? {mem_q[rd_q], {LB{1'b0}}}
                     : '0;

  pref_recent_filter #(
    .FILTER_SIZE(FILTER_SIZE)
  ) u_filter (
    .clk           (clk),
    .rst           (rst),
    .insert_valid_i(issue),
    .insert_line_i (mem_q[rd_q]),
    .lookup_line1_i(line[0]),
    .lookup_line2_i(line[1]),
    .lookup_line3_i(line[2]),
    .hit1_o        (fhit[0]),
    .hit2_o        (fhit[1]),
    .hit3_o        (fhit[2])
  );

  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] a,
    input logic [1:0]           inc
  );
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH+1)'(inc);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  always_comb begin
    logic [CW-1:0] free;
    logic [PW-1:0] wptr;
    logic [PW-1:0] off;
    logic          qhit, ehit;
    dup   = '0;
    enq   = '0;
    fdrop = '0;
    qv    = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      off   = PW'(i) - rd_q;
      qv[i] = {1'b0, off} < cnt_q;
    end
    // a pop this cycle frees its slot for the candidates
    free = CW'(QUEUE_DEPTH) - cnt_q + CW'(issue);
    wptr = wr_q;
    for (int k = 0; k < 3; k++) begin
      qhit = 1'b0;
      ehit = 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++)
        if (qv[i] && mem_q[i] == line[k]) qhit = 1'b1;
      for (int j = 0; j < k; j++)
        if (enq[j] && line[j] == line[k]) ehit = 1'b1;
      dup[k]   = cv[k] & (qhit | fhit[k] | ehit);
      enq[k]   = cv[k] & ~dup[k] & (free != '0);
      fdrop[k] = cv[k] & ~dup[k] & ~enq[k];
      widx[k]  = wptr;
      if (enq[k]) begin
        wptr = wptr + 1'b1;
        free = free - 1'b1;
      end
    end
    wr_d   = wptr;
    rd_d   = rd_q + PW'(issue);
    cnt_d  = cnt_q + CW'($countones(enq)) - CW'(issue);
    iss_d  = sat_add(iss_q, {1'b0, issue});
    dup_d  = sat_add(dup_q, 2'($countones(dup)));
    full_d = sat_add(full_q, 2'($countones(fdrop)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      iss_q  <= '0;
      dup_q  <= '0;
      full_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      iss_q  <= iss_d;
      dup_q  <= dup_d;
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      for (int k = 0; k < 3; k++)
        if (enq[k]) mem_q[widx[k]] <= line[k];
  end

  assign issued_cnt_o    = iss_q;
  assign dup_drop_cnt_o  = dup_q;
  assign full_drop_cnt_o = full_q;
endmodule
